// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin sharing of one 8-bit async SRAM between
// video fetch and CPU, with byte-split words and programmable timing.
module sram_arbiter #(
  parameter int ACCESS_CYCLES = 2,
  parameter int WE_CYCLES     = 2
) (
  input  logic        clk_100,
  input  logic        reset,
  input  logic        vid_req,
  input  logic [20:0] vid_addr,
  output logic        vid_ack,
  output logic [15:0] vid_rdata,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic        cpu_word,
  input  logic [20:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_ack,
  output logic [15:0] cpu_rdata,
  output logic [20:0] SRAM_ADDR,
  output logic        SRAM_WE_n,
  output logic [7:0]  sram_dq_o,
  output logic        sram_dq_oe,
  input  logic [7:0]  sram_dq_i
);

  typedef enum logic [2:0] {
    IDLE, RD, RD_ACK, WR_SETUP, WR_PULSE, WR_HOLD
  } state_t;

  localparam logic [3:0] AC_LAST = 4'(ACCESS_CYCLES - 1);
  localparam logic [3:0] WE_LAST = 4'(WE_CYCLES - 1);

  state_t      state, state_d;
  logic [3:0]  cnt, cnt_d;
  logic        own_cpu, own_cpu_d;
  logic        last_cpu, last_cpu_d;
  logic        word, word_d;
  logic        b, b_d;
  logic [15:0] wdata, wdata_d;
  logic [7:0]  lo, lo_d;
  logic [20:0] addr_d;
  logic        we_n_d, oe_d;
  logic [7:0]  dq_d;
  logic        vid_ack_d, cpu_ack_d;
  logic [15:0] vid_rdata_d, cpu_rdata_d;
  logic [15:0] rd;
  logic        gnt_cpu;

  // On a tie the requester not served last wins
  assign gnt_cpu = cpu_req & (~vid_req | ~last_cpu);

  always_ff @(posedge clk_100) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      own_cpu    <= 1'b0;
      last_cpu   <= 1'b0;
      word       <= 1'b0;
      b          <= 1'b0;
      wdata      <= '0;
      lo         <= '0;
      SRAM_ADDR  <= '0;
      SRAM_WE_n  <= 1'b1;
      sram_dq_o  <= '0;
      sram_dq_oe <= 1'b0;
      vid_ack    <= 1'b0;
      cpu_ack    <= 1'b0;
      vid_rdata  <= '0;
      cpu_rdata  <= '0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      own_cpu    <= own_cpu_d;
      last_cpu   <= last_cpu_d;
      word       <= word_d;
      b          <= b_d;
      wdata      <= wdata_d;
      lo         <= lo_d;
      SRAM_ADDR  <= addr_d;
      SRAM_WE_n  <= we_n_d;
      sram_dq_o  <= dq_d;
      sram_dq_oe <= oe_d;
      vid_ack    <= vid_ack_d;
      cpu_ack    <= cpu_ack_d;
      vid_rdata  <= vid_rdata_d;
      cpu_rdata  <= cpu_rdata_d;
    end
  end

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    own_cpu_d   = own_cpu;
    last_cpu_d  = last_cpu;
    word_d      = word;
    b_d         = b;
    wdata_d     = wdata;
    lo_d        = lo;
    addr_d      = SRAM_ADDR;
    we_n_d      = 1'b1;
    oe_d        = 1'b0;
    dq_d        = sram_dq_o;
    vid_ack_d   = 1'b0;
    cpu_ack_d   = 1'b0;
    vid_rdata_d = vid_rdata;
    cpu_rdata_d = cpu_rdata;
    rd          = '0;
    unique case (state)
      IDLE: begin
        if (cpu_req | vid_req) begin
          own_cpu_d  = gnt_cpu;
          last_cpu_d = gnt_cpu;
          b_d        = 1'b0;
          cnt_d      = '0;
          word_d     = gnt_cpu ? cpu_word : 1'b1;
          wdata_d    = cpu_wdata;
          addr_d     = gnt_cpu ? cpu_addr : vid_addr;
          if (gnt_cpu & cpu_we) begin
            state_d = WR_SETUP;
            oe_d    = 1'b1;
            dq_d    = cpu_wdata[7:0];
          end else begin
            state_d = RD;
          end
        end
      end
      RD: begin
        cnt_d = cnt + 4'd1;
        if (cnt == AC_LAST) begin
          cnt_d = '0;
          if (word & ~b) begin
            b_d    = 1'b1;
            lo_d   = sram_dq_i;
            addr_d = SRAM_ADDR + 21'd1;
          end else begin
            state_d = RD_ACK;
            rd = word ? {sram_dq_i, lo} : {8'h00, sram_dq_i};
            if (own_cpu) begin
              cpu_ack_d   = 1'b1;
              cpu_rdata_d = rd;
            end else begin
              vid_ack_d   = 1'b1;
              vid_rdata_d = rd;
            end
          end
        end
      end
      RD_ACK: state_d = IDLE;
      WR_SETUP: begin
        oe_d    = 1'b1;
        we_n_d  = 1'b0;
        cnt_d   = '0;
        state_d = WR_PULSE;
      end
      WR_PULSE: begin
        oe_d  = 1'b1;
        cnt_d = cnt + 4'd1;
        if (cnt == WE_LAST) begin
          state_d   = WR_HOLD;
          cpu_ack_d = ~(word & ~b);
        end else begin
          we_n_d = 1'b0;
        end
      end
      WR_HOLD: begin
        if (word & ~b) begin
          b_d     = 1'b1;
          oe_d    = 1'b1;
          addr_d  = SRAM_ADDR + 21'd1;
          dq_d    = wdata[15:8];
          state_d = WR_SETUP;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: scoreboard bench with SRAM model, reference memory,
// protocol monitor and a second fast-timing instance.
module tb_sram_arbiter;
  localparam int AC = 2;
  localparam int WC = 2;

  typedef struct {
    bit          we;
    bit          word;
    logic [20:0] addr;
    logic [15:0] data;
    int          t0;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        vid_req = 1'b0;
  logic [20:0] vid_addr = '0;
  logic        vid_ack;
  logic [15:0] vid_rdata;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic        cpu_word = 1'b0;
  logic [20:0] cpu_addr = '0;
  logic [15:0] cpu_wdata = '0;
  logic        cpu_ack;
  logic [15:0] cpu_rdata;
  logic [20:0] sram_addr;
  logic        sram_we_n;
  logic [7:0]  dq_o;
  logic        dq_oe;
  logic [7:0]  dq_i = '0;

  logic        s_cpu_req = 1'b0;
  logic        s_cpu_we = 1'b0;
  logic [20:0] s_cpu_addr = '0;
  logic [15:0] s_cpu_wdata = '0;
  logic        s_cpu_ack, s_vid_ack;
  logic [15:0] s_cpu_rdata, s_vid_rdata;
  logic [20:0] s_addr;
  logic        s_we_n, s_dq_oe;
  logic [7:0]  s_dq_o;
  logic [7:0]  s_dq_i = '0;

  sram_arbiter #(.ACCESS_CYCLES(AC), .WE_CYCLES(WC)) dut (
    .clk_100(clk), .reset(reset),
    .vid_req(vid_req), .vid_addr(vid_addr),
    .vid_ack(vid_ack), .vid_rdata(vid_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_word(cpu_word),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .SRAM_ADDR(sram_addr), .SRAM_WE_n(sram_we_n),
    .sram_dq_o(dq_o), .sram_dq_oe(dq_oe), .sram_dq_i(dq_i)
  );

  sram_arbiter #(.ACCESS_CYCLES(1), .WE_CYCLES(1)) fast (
    .clk_100(clk), .reset(reset),
    .vid_req(1'b0), .vid_addr(21'h0),
    .vid_ack(s_vid_ack), .vid_rdata(s_vid_rdata),
    .cpu_req(s_cpu_req), .cpu_we(s_cpu_we), .cpu_word(1'b0),
    .cpu_addr(s_cpu_addr), .cpu_wdata(s_cpu_wdata),
    .cpu_ack(s_cpu_ack), .cpu_rdata(s_cpu_rdata),
    .SRAM_ADDR(s_addr), .SRAM_WE_n(s_we_n),
    .sram_dq_o(s_dq_o), .sram_dq_oe(s_dq_oe), .sram_dq_i(s_dq_i)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Asynchronous SRAM models: bytes latch on the rising edge of WE_n
  logic [7:0] mem [0:2097151];
  logic [7:0] mem1 [0:255];
  always @(posedge sram_we_n) if (!reset && dq_oe) mem[sram_addr] <= dq_o;
  always @(negedge clk) dq_i <= mem[sram_addr];
  always @(posedge s_we_n) if (!reset && s_dq_oe) mem1[s_addr[7:0]] <= s_dq_o;
  always @(negedge clk) s_dq_i <= mem1[s_addr[7:0]];

  logic [7:0] ref_mem [logic [20:0]];
  exp_t cpu_q[$];
  exp_t vid_q[$];
  bit   ack_log[$];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] ref_rd(input logic [20:0] a,
                                         input bit wd);
    logic [20:0] a1;
    a1 = a + 21'd1;
    return wd ? {ref_mem[a1], ref_mem[a]} : {8'h00, ref_mem[a]};
  endfunction

  task automatic score(input bit is_cpu);
    exp_t e;
    logic [15:0] got;
    ack_log.push_back(is_cpu);
    if ((is_cpu && cpu_q.size() == 0) || (!is_cpu && vid_q.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL spurious_ack: cpu=%0d at cycle %0d", is_cpu, cyc);
      return;
    end
    if (is_cpu) e = cpu_q.pop_front();
    else e = vid_q.pop_front();
    if (e.we)
      got = e.word ? {mem[e.addr + 21'd1], mem[e.addr]}
                   : {8'h00, mem[e.addr]};
    else
      got = is_cpu ? cpu_rdata : vid_rdata;
    check(is_cpu ? (e.we ? "cpu_wr_mem" : "cpu_rdata") : "vid_rdata",
          32'(got), 32'(e.data));
    if (!e.we) check("rd_oe_low", 32'(dq_oe), 0);
    if (e.lat != 0) check("latency", cyc - e.t0, e.lat);
  endtask

  // Scoreboard monitor and write-strobe protocol monitor
  logic [20:0] p_addr = '0;
  logic [7:0]  p_dq = '0;
  logic        p_we_n = 1'b1;
  int          wlen = 0;
  always @(negedge clk) begin
    if (cpu_ack | vid_ack) check("ack_excl", 32'(cpu_ack & vid_ack), 0);
    if (cpu_ack) score(1'b1);
    if (vid_ack) score(1'b0);
    if (reset) begin
      wlen = 0;
      p_we_n = 1'b1;
    end else if (!sram_we_n) begin
      wlen++;
      check("we_stable", {dq_oe, 2'b00, sram_addr, dq_o},
            {1'b1, 2'b00, p_addr, p_dq});
    end else if (!p_we_n) begin
      check("we_len", wlen, WC);
      check("hold_stable", {dq_oe, 2'b00, sram_addr, dq_o},
            {1'b1, 2'b00, p_addr, p_dq});
      wlen = 0;
    end
    if (!reset) begin
      p_addr = sram_addr;
      p_dq = dq_o;
      p_we_n = sram_we_n;
    end
  end

  task automatic wait_ack(input bit is_cpu);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(is_cpu ? cpu_ack : vid_ack) && n < 200);
    if (!(is_cpu ? cpu_ack : vid_ack)) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: cpu=%0d waited %0d cycles", is_cpu, n);
    end
    @(posedge clk);
    #1;
    if (is_cpu) cpu_req = 1'b0;
    else vid_req = 1'b0;
  endtask

  task automatic cpu_op(input bit we, input bit wd, input logic [20:0] a,
                        input logic [15:0] d, input int lat);
    exp_t e;
    e.we = we;
    e.word = wd;
    e.addr = a;
    e.t0 = cyc;
    e.lat = lat;
    if (we) begin
      ref_mem[a] = d[7:0];
      if (wd) ref_mem[a + 21'd1] = d[15:8];
      e.data = wd ? d : {8'h00, d[7:0]};
    end else begin
      e.data = ref_rd(a, wd);
    end
    cpu_q.push_back(e);
    cpu_we = we;
    cpu_word = wd;
    cpu_addr = a;
    cpu_wdata = d;
    cpu_req = 1'b1;
    wait_ack(1'b1);
  endtask

  task automatic vid_op(input logic [20:0] a, input int lat);
    exp_t e;
    e.we = 1'b0;
    e.word = 1'b1;
    e.addr = a;
    e.data = ref_rd(a, 1'b1);
    e.t0 = cyc;
    e.lat = lat;
    vid_q.push_back(e);
    vid_addr = a;
    vid_req = 1'b1;
    wait_ack(1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  int t0, n, lowc;
  logic [20:0] ra;

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_rdata", {cpu_rdata, vid_rdata}, 0);
    check("rst_dq_o", 32'(dq_o), 0);
    repeat (20) begin
      @(negedge clk);
      check("reset_idle", {cpu_ack, vid_ack, dq_oe, sram_we_n, sram_addr},
            {4'b0001, 21'h0});
    end
    @(posedge clk);
    #1;
    cpu_op(1'b1, 1'b0, 21'h00010, 16'h00A5, 2 + WC);
    cpu_op(1'b0, 1'b0, 21'h00010, 16'h0000, 1 + AC);
    cpu_op(1'b1, 1'b1, 21'h1FFFFF, 16'hBEEF, 2 * (2 + WC));
    check("wrap_lo", 32'(mem[21'h1FFFFF]), 32'h00EF);
    check("wrap_hi", 32'(mem[21'h000000]), 32'h00BE);
    vid_op(21'h1FFFFF, 1 + 2 * AC);
    for (int k = 0; k < 32; k++)
      cpu_op(1'b1, 1'b1, 21'h100000 + 21'(2 * k), 16'($urandom),
             2 * (2 + WC));
    for (int k = 0; k < 16; k++)
      cpu_op(1'b1, 1'b1, 21'h1FFFF0 + 21'(2 * k), 16'($urandom), 0);
    vid_op(21'h100004, 1 + 2 * AC);

    ack_log.delete();
    fork
      for (int k = 0; k < 3; k++)
        cpu_op(1'(k), 1'b1, 21'h1FFFF4 + 21'(2 * k), 16'($urandom), 0);
      for (int k = 0; k < 3; k++)
        vid_op(21'h100010 + 21'(2 * k), 0);
    join
    check("arb_count", ack_log.size(), 6);
    for (int k = 0; k < ack_log.size() && k < 6; k++)
      check("arb_order", 32'(ack_log[k]), 32'(k % 2 == 0));

    cpu_we = 1'b1;
    cpu_word = 1'b1;
    cpu_addr = 21'h000500;
    cpu_wdata = 16'h1234;
    cpu_req = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    cpu_req = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_out", {cpu_ack, dq_oe, sram_we_n, sram_addr},
          {3'b001, 21'h0});
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("midrst_no_ack", 32'(cpu_ack), 0);
    end
    @(posedge clk);
    #1;
    cpu_op(1'b0, 1'b0, 21'h00010, 16'h0000, 1 + AC);
    vid_op(21'h1FFFFF, 1 + 2 * AC);

    fork
      for (int k = 0; k < 40; k++) begin
        cpu_op(1'($urandom), 1'($urandom),
               21'h1FFFF0 + 21'($urandom_range(0, 31)),
               16'($urandom), 0);
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
      for (int k = 0; k < 40; k++) begin
        vid_op(21'h100000 + 21'($urandom_range(0, 62)), 0);
        repeat ($urandom_range(0, 3)) begin
          @(posedge clk);
          #1;
        end
      end
    join
    repeat (4) @(posedge clk);
    check("queues_drained", cpu_q.size() + vid_q.size(), 0);

    #1;
    s_cpu_we = 1'b1;
    s_cpu_addr = 21'h000020;
    s_cpu_wdata = 16'h003C;
    t0 = cyc;
    s_cpu_req = 1'b1;
    n = 0;
    lowc = 0;
    do begin
      @(negedge clk);
      if (!s_we_n) lowc++;
      n++;
    end while (!s_cpu_ack && n < 50);
    check("fast_wr_lat", cyc - t0, 3);
    check("fast_we_low", lowc, 1);
    check("fast_wr_mem", {s_addr, mem1[8'h20]}, {21'h20, 8'h3C});
    @(posedge clk);
    #1 s_cpu_req = 1'b0;
    s_cpu_we = 1'b0;
    @(posedge clk);
    #1;
    t0 = cyc;
    s_cpu_req = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!s_cpu_ack && n < 50);
    check("fast_rd_lat", cyc - t0, 2);
    check("fast_rdata", 32'(s_cpu_rdata), 32'h003C);
    check("fast_vid_idle", {s_vid_ack, s_vid_rdata}, 0);
    @(posedge clk);
    #1 s_cpu_req = 1'b0;
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Sequences the board's single 8-bit asynchronous SRAM (512 KB fitted, 21-bit address bus) and shares it between the VGA fetch engine and the CPU/chipset bus. It splits 16-bit accesses into two byte cycles and generates glitch-free SRAM_WE_n timing from programmable cycle counts. It arbitrates round-robin so video fetch latency is bounded by one CPU transaction. It sits inside `system` on the clk_100 domain, between the requesters and the top-level SRAM pins; the top level owns the tristate buffer.

## Interface
- ACCESS_CYCLES, 2, read access cycles per byte (1..15)
- WE_CYCLES, 2, SRAM_WE_n low cycles per byte write (1..15)

- clk_100  in  1  system clock; only clock
- reset  in  1  synchronous, active-high
- vid_req  in  1  video read request, level, held until vid_ack
- vid_addr  in  21  byte address of 16-bit little-endian word
- vid_ack  out  1  one-cycle pulse; vid_rdata valid in same cycle
- vid_rdata  out  16  {byte[addr+1], byte[addr]}
- cpu_req  in  1  CPU request, level, fields stable until cpu_ack
- cpu_we  in  1  1 = write
- cpu_word  in  1  1 = 16-bit access, 0 = byte
- cpu_addr  in  21  byte address
- cpu_wdata  in  16  write data; [7:0] only for byte access
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  16  read data; byte reads zero-extend into [15:8]
- SRAM_ADDR  out  21  SRAM address, registered
- SRAM_WE_n  out  1  write enable, active low, registered
- sram_dq_o  out  8  write data to pins
- sram_dq_oe  out  1  drive enable for sram_dq_o
- sram_dq_i  in  8  data from pins

## Operation
- States: IDLE, RD, RD_ACK, WR_SETUP, WR_PULSE, WR_HOLD.
- Arbitration happens only in IDLE. If one req is high, that requester is granted. If both are high, the requester not served last is granted; after reset, video counts as last-served, so CPU wins the first tie.
- The grant latches the address, we, word flag and wdata. Byte index b=0; a word access runs b=0, then b=1 at address+1. The address wraps modulo 2^21 (0x1FFFFF+1 -> 0x000000).
- Video is always a word read (we=0, word=1).
- RD: SRAM_ADDR is held for ACCESS_CYCLES cycles and sram_dq_i is captured on the final edge into byte b. If b=0 and the access is a word, b becomes 1 and RD repeats at address+1; otherwise go to RD_ACK.
- RD_ACK: one cycle; the granted ack is high and rdata is updated (registered); then IDLE.
- WR_SETUP: one cycle; address and sram_dq_o are valid, sram_dq_oe=1, SRAM_WE_n=1.
- WR_PULSE: SRAM_WE_n=0 for WE_CYCLES cycles.
- WR_HOLD: one cycle; SRAM_WE_n=1 with address and data held.
  - If a second byte remains, go to WR_SETUP with b=1.
  - Otherwise assert ack in this cycle and go to IDLE.
- sram_dq_oe=1 only in WR_SETUP, WR_PULSE and WR_HOLD; it is 0 in every read state.
- SRAM_ADDR and sram_dq_o never change while SRAM_WE_n=0.
- A requester whose req is still high in the cycle after its ack is issuing a new transaction.
- Reset values: SRAM_WE_n=1, sram_dq_oe=0, SRAM_ADDR=0, sram_dq_o=0, both acks 0, both rdata 0, state IDLE.
- Reset mid-transaction: on the reset edge all outputs return to reset values, the transaction is abandoned and no ack is issued. A write may leave the target byte corrupted.

## Timing
- All outputs are registered. Edge 0 is the IDLE edge that samples req.
- Byte read: ack in cycle 1+ACCESS_CYCLES after edge 0 (default: edge 3).
- Word read: ack in cycle 1+2·ACCESS_CYCLES (default 5).
- Byte write: ack coincides with WR_HOLD at cycle 2+WE_CYCLES (default 4).
- Word write: ack at cycle 2·(2+WE_CYCLES) (default 8).
- The earliest next grant is on the edge ending the ack cycle plus one (IDLE), so there is one idle cycle between transactions.
- Worst-case video wait from req to grant is one CPU word write plus one IDLE cycle.

## Test plan
- After reset with both req low: SRAM_WE_n=1, sram_dq_oe=0, SRAM_ADDR=0, no ack for 20 cycles.
- CPU byte write 0xA5 to 0x00010, then byte read of 0x00010:
  - write: WE_n low for exactly 2 cycles with ADDR and dq stable from setup through hold; ack at cycle 4;
  - read: cpu_rdata=0x00A5, ack at cycle 3.
- CPU word write 0xBEEF to 0x1FFFFF:
  - SRAM model shows 0xEF at 0x1FFFFF and 0xBE at 0x000000;
  - a video word read of 0x1FFFFF returns 0xBEEF at cycle 5.
- vid_req and cpu_req held high together for 6 transactions: grants alternate CPU, video, CPU, ...; no ack is ever high for both requesters in the same cycle.
- Reset asserted during the second WR_PULSE cycle of a word write: on the next edge WE_n=1 and oe=0, no cpu_ack, state IDLE; a subsequent read proceeds normally.
- ACCESS_CYCLES=1, WE_CYCLES=1 build: byte read ack at cycle 2, byte write ack at cycle 3, WE_n low for 1 cycle.
